// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    // Column 0 driven low, all others released.
    localparam logic [3:0] COL_N_RESET = 4'b1110;

    // Key legend of the Pmod KYPD: row-major, row 3 is the odd one out.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; only q is safe to use downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates a low column, samples rows once per dwell,
// debounces a single-row press and reports a hex code with a valid strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 100000,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SETTLE_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);

    logic [3:0]    row_sync;
    logic [DW-1:0] dwell;
    logic          sample;
    logic          single_low;
    logic [1:0]    row_idx;
    state_t        state;
    logic [1:0]    col_idx;
    logic [1:0]    cand_row;
    logic [CW-1:0] deb_cnt;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_sync)
    );

    assign sample = (dwell == DW'(SETTLE_CYCLES - 1));

    // A press is exactly one row low; chords and idle both read as no press.
    always_comb begin
        single_low = 1'b0;
        row_idx    = 2'd0;
        case (row_sync)
            4'b1110: begin single_low = 1'b1; row_idx = 2'd0; end
            4'b1101: begin single_low = 1'b1; row_idx = 2'd1; end
            4'b1011: begin single_low = 1'b1; row_idx = 2'd2; end
            4'b0111: begin single_low = 1'b1; row_idx = 2'd3; end
            default: begin single_low = 1'b0; row_idx = 2'd0; end
        endcase
    end

    // Free-running dwell counter; a release also lands on a sample, so the
    // wrap to 0 there doubles as the restart for column 0.
    always_ff @(posedge clk) begin
        if (reset)       dwell <= '0;
        else if (sample) dwell <= '0;
        else             dwell <= dwell + 1'b1;
    end

    // Scan / confirm / held FSM; column and key outputs are all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_n     <= COL_N_RESET;
            cand_row  <= 2'd0;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (single_low) begin
                            cand_row <= row_idx;
                            deb_cnt  <= CW'(1);
                            state    <= CONFIRM;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                            col_n   <= {col_n[2:0], col_n[3]};
                        end
                    end
                    CONFIRM: begin
                        if (single_low && row_idx == cand_row) begin
                            if (deb_cnt == CW'(DEBOUNCE_COUNT - 1)) begin
                                key_code  <= key_map(cand_row, col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                            state   <= SCAN;
                            col_idx <= col_idx + 1'b1;
                            col_n   <= {col_n[2:0], col_n[3]};
                        end
                    end
                    HELD: begin
                        if (single_low) begin
                            deb_cnt <= '0;
                        end else if (deb_cnt == CW'(DEBOUNCE_COUNT - 1)) begin
                            deb_cnt  <= '0;
                            key_held <= 1'b0;
                            state    <= SCAN;
                            col_idx  <= 2'd0;
                            col_n    <= COL_N_RESET;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: behavioural keypad, cycle model, scenario checks.
module tb_keypad_scanner;

    localparam int S = 4;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = 16'h0;   // bit r*4+c = key at row r, col c held down

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic [3:0] last_code = 4'h0;

    keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_COUNT(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its row to its column when driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};
    int         m_phase = 0, m_mode = 0, m_col = 0, m_cnt = 0, m_row = 0;
    logic [3:0] h1 = 4'hF, h2 = 4'hF;
    logic [3:0] e_col_n = 4'b1110, e_code = 4'h0;
    logic       e_valid = 1'b0, e_held = 1'b0;
    logic       model_ok = 1'b0;

    always @(posedge clk) begin
        logic [3:0] seen, rows_now, lows;
        int nlow, r;
        if (reset) begin
            h1 = 4'hF; h2 = 4'hF;
            m_phase = 0; m_mode = 0; m_col = 0; m_cnt = 0; m_row = 0;
            e_code = 4'h0; e_valid = 1'b0; e_held = 1'b0;
            model_ok = 1'b1;
        end else begin
            rows_now = 4'hF;
            for (int rr = 0; rr < 4; rr++)
                if (pressed[rr*4+m_col]) rows_now[rr] = 1'b0;
            seen = h2; h2 = h1; h1 = rows_now;
            e_valid = 1'b0;
            if (m_phase == S-1) begin
                m_phase = 0;
                lows = ~seen;
                nlow = $countones(lows);
                r = 0;
                for (int rr = 0; rr < 4; rr++) if (lows[rr]) r = rr;
                if (m_mode == 0) begin
                    if (nlow == 1) begin m_row = r; m_cnt = 1; m_mode = 1; end
                    else m_col = (m_col + 1) % 4;
                end else if (m_mode == 1) begin
                    if (nlow == 1 && r == m_row) begin
                        m_cnt++;
                        if (m_cnt == D) begin
                            e_code = keymap[m_row*4+m_col];
                            e_valid = 1'b1; e_held = 1'b1; m_mode = 2; m_cnt = 0;
                        end
                    end else begin
                        m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
                    end
                end else begin
                    if (nlow == 1) m_cnt = 0;
                    else begin
                        m_cnt++;
                        if (m_cnt == D) begin m_mode = 0; m_cnt = 0; m_col = 0; e_held = 1'b0; end
                    end
                end
            end else begin
                m_phase++;
            end
        end
        e_col_n = ~(4'b0001 << m_col);
    end

    // Per-cycle compare against the model, plus strobe bookkeeping.
    always @(negedge clk) begin
        if (model_ok)
            check("cycle", {col_n, key_code, key_valid, key_held},
                           {e_col_n, e_code, e_valid, e_held});
        if (key_valid === 1'b1) begin
            pulses++;
            last_code = key_code;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; pressed = 16'h0;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        int p0, n;
        logic [15:0] m;
        bit got;

        // Reset values and idle rotation
        cycles(3);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        check("rst_code", key_code, 4'h0);
        reset = 1'b0;
        cycles(4);  check("rot_col1", col_n, 4'b1101);
        cycles(4);  check("rot_col2", col_n, 4'b1011);
        cycles(4);  check("rot_col3", col_n, 4'b0111);
        cycles(4);  check("rot_col0", col_n, 4'b1110);

        // Reset during CONFIRM of 'A' (row0, col3)
        do_reset();
        pressed = 16'h0008;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (m_mode == 1) got = 1;
        end
        check("confirm_reached", got, 1'b1);
        p0 = pulses;
        reset = 1'b1; pressed = 16'h0;
        @(negedge clk);
        check("rstc_col_n", col_n, 4'b1110);
        check("rstc_valid", key_valid, 1'b0);
        check("rstc_code", key_code, 4'h0);
        check("rstc_held", key_held, 1'b0);
        reset = 1'b0;
        cycles(20);
        check("rstc_no_pulse", pulses - p0, 0);

        // Key '5' held from reset: detecting sample at cycle 7, valid after edge 16
        @(negedge clk); reset = 1'b1; pressed = 16'h0020;
        @(negedge clk); reset = 1'b0;
        p0 = pulses;
        cycles(15); check("k5_not_yet", key_valid, 1'b0);
        cycles(1);
        check("k5_valid", key_valid, 1'b1);
        check("k5_code", key_code, 4'h5);
        check("k5_held", key_held, 1'b1);
        cycles(40);
        check("k5_still_held", key_held, 1'b1);
        pressed = 16'h0;
        cycles(30);
        check("k5_released", key_held, 1'b0);
        check("k5_one_pulse", pulses - p0, 1);
        check("k5_code_kept", key_code, 4'h5);

        // Bounce on 'D' (row3, col3), toggling once per sample period
        do_reset();
        p0 = pulses;
        cycles(13);
        for (int i = 0; i < 4; i++) begin
            pressed = pressed ^ 16'h8000;
            cycles(S);
        end
        pressed = 16'h8000;
        cycles(60);
        check("bounce_one_pulse", pulses - p0, 1);
        check("bounce_code", last_code, 4'hD);
        pressed = 16'h0;
        cycles(30);

        // Chord '1' + '4' (same column): never accepted, scanning continues
        do_reset();
        p0 = pulses;
        pressed = 16'h0011;
        cycles(100);
        check("chord_no_pulse", pulses - p0, 0);
        pressed = 16'h0;
        cycles(20);

        // Randomized presses, chords, gaps and occasional resets
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(99);
            m = 16'h0;
            if (n < 65) m[$urandom_range(15)] = 1'b1;
            else if (n < 85) begin
                m[$urandom_range(15)] = 1'b1;
                m[$urandom_range(15)] = 1'b1;
            end
            pressed = m;
            if ($urandom_range(19) == 0) begin
                reset = 1'b1; @(negedge clk); reset = 1'b0;
            end
            cycles($urandom_range(80, 5));
        end
        pressed = 16'h0;
        cycles(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
